// File: rtl/rf_mp.sv
// Multi-port general-purpose register file with two prioritised write ports,
// same-cycle write-to-read bypass and a per-register busy scoreboard.
module rf_mp #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NRD     = 2,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  output logic [NRD-1:0]    rbusy,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic              iss,
  input  logic [AW-1:0]     iss_a,
  output logic              any_busy
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0]    r_mem [Depth];
  logic [Depth-1:0] r_busy;
  logic [Depth-1:0] w_busy_d;
  logic             w_wr0;
  logic             w_wr1;
  logic             w_set;

  assign w_wr0 = we0 && !(ZERO_R0 && (wa0 == '0));
  assign w_wr1 = we1 && !(ZERO_R0 && (wa1 == '0));
  assign w_set = iss && !(ZERO_R0 && (iss_a == '0));

  // Clears first, then the set, so a new producer supersedes the retiring one.
  always_comb begin
    w_busy_d = r_busy;
    if (we0) w_busy_d[wa0] = 1'b0;
    if (we1) w_busy_d[wa1] = 1'b0;
    if (w_set) w_busy_d[iss_a] = 1'b1;
  end

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr0) r_mem[wa0] <= wd0;
      if (w_wr1) r_mem[wa1] <= wd1;
      r_busy <= w_busy_d;
    end
  end

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_hit0;
    logic          w_hit1;
    logic          w_zero;

    assign w_addr = ra[k*AW +: AW];
    assign w_hit0 = we0 && (wa0 == w_addr);
    assign w_hit1 = we1 && (wa1 == w_addr);
    assign w_zero = ZERO_R0 && (w_addr == '0);

    assign rd[k*DW +: DW] = (!rst || w_zero) ? '0 :
                            w_hit1           ? wd1 :
                            w_hit0           ? wd0 : r_mem[w_addr];
    // A register being written this cycle is bypassed, so it is not a hazard.
    assign rbusy[k] = rst && !w_zero && r_busy[w_addr] && !w_hit0 && !w_hit1;
  end

  assign any_busy = rst && (|r_busy);

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp: directed vector table, reset sequence,
// randomized run against a behavioural model, and a 16x8/4-port sweep.
module tb_rf_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default configuration DUT
  logic [9:0]  a_ra;
  logic [63:0] a_rd;
  logic [1:0]  a_rbusy;
  logic        a_we0, a_we1, a_iss, a_any;
  logic [4:0]  a_wa0, a_wa1, a_iss_a;
  logic [31:0] a_wd0, a_wd1;

  rf_mp #(.DW(32), .AW(5), .NRD(2), .ZERO_R0(1'b1)) u_a (
    .clk(clk), .rst(rst), .ra(a_ra), .rd(a_rd), .rbusy(a_rbusy),
    .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0), .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
    .iss(a_iss), .iss_a(a_iss_a), .any_busy(a_any)
  );

  // Sweep DUTs share inputs; one with a hardwired r0, one without
  logic [11:0] b_ra;
  logic [63:0] b_rd, c_rd;
  logic [3:0]  b_rbusy, c_rbusy;
  logic        b_we0, b_we1, b_iss, b_any, c_any;
  logic [2:0]  b_wa0, b_wa1, b_iss_a;
  logic [15:0] b_wd0, b_wd1;

  rf_mp #(.DW(16), .AW(3), .NRD(4), .ZERO_R0(1'b1)) u_b (
    .clk(clk), .rst(rst), .ra(b_ra), .rd(b_rd), .rbusy(b_rbusy),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .iss(b_iss), .iss_a(b_iss_a), .any_busy(b_any)
  );

  rf_mp #(.DW(16), .AW(3), .NRD(4), .ZERO_R0(1'b0)) u_c (
    .clk(clk), .rst(rst), .ra(b_ra), .rd(c_rd), .rbusy(c_rbusy),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .iss(b_iss), .iss_a(b_iss_a), .any_busy(c_any)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model of the default DUT: architectural state plus spec rules
  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (a_we1 && a_wa1 == a) return a_wd1;
    if (a_we0 && a_wa0 == a) return a_wd0;
    return m_mem[a];
  endfunction

  function automatic logic m_rb(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if ((a_we1 && a_wa1 == a) || (a_we0 && a_wa0 == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic m_any();
    logic r = 1'b0;
    for (int i = 0; i < 32; i++) r = r | m_busy[i];
    return r;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic m_edge();
    if (a_we0 && a_wa0 != 0) m_mem[a_wa0] = a_wd0;
    if (a_we1 && a_wa1 != 0) m_mem[a_wa1] = a_wd1;
    if (a_we0) m_busy[a_wa0] = 1'b0;
    if (a_we1) m_busy[a_wa1] = 1'b0;
    if (a_iss && a_iss_a != 0) m_busy[a_iss_a] = 1'b1;
  endtask

  task automatic drive_a(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic iss, input logic [4:0] iss_a,
                         input logic [4:0] ra0, input logic [4:0] ra1);
    a_we0 = we0; a_wa0 = wa0; a_wd0 = wd0;
    a_we1 = we1; a_wa1 = wa1; a_wd1 = wd1;
    a_iss = iss; a_iss_a = iss_a;
    a_ra  = {ra1, ra0};
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".rd0"}, {32'h0, a_rd[31:0]},  {32'h0, m_rd(a_ra[4:0])});
    chk({tag, ".rd1"}, {32'h0, a_rd[63:32]}, {32'h0, m_rd(a_ra[9:5])});
    chk({tag, ".rb0"}, {63'h0, a_rbusy[0]},  {63'h0, m_rb(a_ra[4:0])});
    chk({tag, ".rb1"}, {63'h0, a_rbusy[1]},  {63'h0, m_rb(a_ra[9:5])});
    chk({tag, ".any"}, {63'h0, a_any},       {63'h0, m_any()});
  endtask

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  iss_a;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_rb0;
    logic        e_rb1;
    logic        e_any;
  } vec_t;

  vec_t vt [17];

  logic [15:0] sw_val [8];
  logic [2:0]  sw_addr [3][4];

  initial begin
    // Hand-derived cycle-by-cycle expectations starting from reset state
    //          we0 wa0 wd0           we1 wa1 wd1    iss ia ra0 ra1 rd0            rd1           rb0 rb1 any
    vt[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 32'h0,  0, 0, 3, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0};
    vt[1]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 3, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0};
    vt[2]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,  0, 0, 3, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0};
    vt[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 3, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0};
    vt[4]  = '{1, 7, 32'h11,       1, 7, 32'h22, 0, 0, 7, 3, 32'h22,       32'hDEADBEEF, 0, 0, 0};
    vt[5]  = '{1, 8, 32'h33,       0, 0, 32'h0,  0, 0, 7, 8, 32'h22,       32'h33,       0, 0, 0};
    vt[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 9, 9, 8, 32'h0,        32'h33,       0, 0, 0};
    vt[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 9, 8, 32'h0,        32'h33,       1, 0, 1};
    vt[8]  = '{0, 0, 32'h0,        1, 9, 32'h55, 0, 0, 9, 8, 32'h55,       32'h33,       0, 0, 1};
    vt[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 9, 8, 32'h55,       32'h33,       0, 0, 0};
    vt[10] = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 4, 4, 8, 32'h0,        32'h33,       0, 0, 0};
    vt[11] = '{1, 4, 32'h44,       0, 0, 32'h0,  1, 4, 4, 8, 32'h44,       32'h33,       0, 0, 1};
    vt[12] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 4, 8, 32'h44,       32'h33,       1, 0, 1};
    vt[13] = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 4, 32'h0,        32'h44,       0, 1, 1};
    vt[14] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 4, 32'h0,        32'h44,       0, 1, 1};
    vt[15] = '{1, 4, 32'h45,       0, 0, 32'h0,  0, 0, 0, 4, 32'h0,        32'h45,       0, 0, 1};
    vt[16] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 4, 32'h0,        32'h45,       0, 0, 0};

    for (int i = 0; i < 8; i++) sw_val[i] = 16'hA000 + 16'(i * 16'h0111);
    sw_addr[0] = '{3'd7, 3'd5, 3'd3, 3'd0};
    sw_addr[1] = '{3'd1, 3'd2, 3'd4, 3'd6};
    sw_addr[2] = '{3'd0, 3'd6, 3'd0, 3'd1};

    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    b_we0 = 0; b_wa0 = 0; b_wd0 = 0; b_we1 = 0; b_wa1 = 0; b_wd1 = 0;
    b_iss = 0; b_iss_a = 0; b_ra = '0;
    m_clear();

    // Reset state with writes being attempted
    a_we0 = 1; a_wa0 = 5; a_wd0 = 32'h99; a_ra = {5'd1, 5'd5};
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rd",    a_rd, 64'h0);
    chk("reset.rbusy", {62'h0, a_rbusy}, 64'h0);
    chk("reset.any",   {63'h0, a_any}, 64'h0);
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive_a(vt[i].we0, vt[i].wa0, vt[i].wd0, vt[i].we1, vt[i].wa1, vt[i].wd1,
              vt[i].iss, vt[i].iss_a, vt[i].ra0, vt[i].ra1);
      #1;
      chk($sformatf("vec%0d.rd0", i), {32'h0, a_rd[31:0]},  {32'h0, vt[i].e_rd0});
      chk($sformatf("vec%0d.rd1", i), {32'h0, a_rd[63:32]}, {32'h0, vt[i].e_rd1});
      chk($sformatf("vec%0d.rb0", i), {63'h0, a_rbusy[0]},  {63'h0, vt[i].e_rb0});
      chk($sformatf("vec%0d.rb1", i), {63'h0, a_rbusy[1]},  {63'h0, vt[i].e_rb1});
      chk($sformatf("vec%0d.any", i), {63'h0, a_any},       {63'h0, vt[i].e_any});
      @(posedge clk);
      m_edge();
    end

    // Mid-cycle reset discards stored data and busy bits
    @(negedge clk);
    drive_a(1, 5, 32'h1234, 0, 0, 0, 1, 5, 0, 0);
    @(posedge clk);
    m_edge();
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    #1;
    chk("prerst.rd0", {32'h0, a_rd[31:0]}, 64'h1234);
    chk("prerst.rb0", {63'h0, a_rbusy[0]}, 64'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("inrst.rd0", {32'h0, a_rd[31:0]}, 64'h0);
    chk("inrst.rb0", {63'h0, a_rbusy[0]}, 64'h0);
    chk("inrst.any", {63'h0, a_any}, 64'h0);
    m_clear();
    drive_a(1, 6, 32'h77, 0, 0, 0, 1, 6, 5, 6);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 5, 6);
    #1;
    chk("postrst.rd0", {32'h0, a_rd[31:0]},  64'h0);
    chk("postrst.rd1", {32'h0, a_rd[63:32]}, 64'h0);
    chk("postrst.rb1", {63'h0, a_rbusy[1]},  64'h0);
    chk("postrst.any", {63'h0, a_any},       64'h0);
    @(posedge clk);
    m_edge();

    // Randomized traffic on a narrow address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive_a(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      #1;
      chk_model($sformatf("rnd%0d", n));
      @(posedge clk);
      m_edge();
    end

    // Parameter sweep: fill r0..r7 alternating write ports
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_we0 = (i % 2 == 0); b_wa0 = 3'(i); b_wd0 = sw_val[i];
      b_we1 = (i % 2 == 1); b_wa1 = 3'(i); b_wd1 = sw_val[i];
      @(posedge clk);
    end
    @(negedge clk);
    b_we0 = 0; b_we1 = 0;
    for (int s = 0; s < 3; s++) begin
      b_ra = {sw_addr[s][3], sw_addr[s][2], sw_addr[s][1], sw_addr[s][0]};
      #1;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("swz%0d.p%0d", s, k), {48'h0, b_rd[k*16 +: 16]},
            {48'h0, (sw_addr[s][k] == 0) ? 16'h0 : sw_val[sw_addr[s][k]]});
        chk($sformatf("swn%0d.p%0d", s, k), {48'h0, c_rd[k*16 +: 16]},
            {48'h0, sw_val[sw_addr[s][k]]});
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_mp.md
# rf_mp

Parameterised multi-port register file for the CPU datapath: the second-generation general-purpose register bank. It has a configurable data width, depth and number of read ports, and two prioritised write ports (ALU writeback and load writeback). It adds same-cycle write-to-read bypass and a per-register busy scoreboard for pipeline hazard detection. It sits between decode, which drives the read ports and issue, and writeback, which drives the write ports.

## Interface
- DW, 32, data width in bits
- AW, 5, address width; depth = 2^AW registers
- NRD, 2, number of read ports (1..4)
- ZERO_R0, 1, when 1, register 0 reads 0, ignores writes and is never busy
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- ra  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rd  out  NRD*DW  read data; port k uses bits [k*DW +: DW]
- rbusy  out  NRD  port k: register ra[k] has a pending, unresolved write
- we0, wa0, wd0  in  1 / AW / DW  write port 0 (ALU writeback)
- we1, wa1, wd1  in  1 / AW / DW  write port 1 (load writeback); higher priority
- iss  in  1  issue strobe: mark register iss_a busy
- iss_a  in  AW  destination register of the issuing instruction
- any_busy  out  1  OR of all busy bits

## Operation
- Storage: 2^AW x DW array plus a 2^AW-bit busy vector.
- Write:
  - At the rising edge, for each port with weN=1, mem[waN] <= wdN.
  - If both ports write the same address in one cycle, port 1's data is stored.
  - With ZERO_R0=1, writes to address 0 are dropped.
- Read (combinational, per port k):
  - If ZERO_R0=1 and ra[k]=0: rd[k]=0.
  - Else if we1 and wa1=ra[k]: rd[k]=wd1.
  - Else if we0 and wa0=ra[k]: rd[k]=wd0.
  - Else: rd[k]=mem[ra[k]].
  - Bypass is purely same-cycle; no registered forwarding.
- Scoreboard, at each rising edge:
  - busy[waN] is cleared for every active write port.
  - Then, if iss=1, busy[iss_a] is set.
  - Set wins over clear on the same address in the same cycle: the new producer supersedes the old one.
  - With ZERO_R0=1, issue to address 0 is ignored.
- rbusy[k] = busy[ra[k]], except:
  - forced 0 when ra[k] is being written this cycle by either port, because the data is bypassed;
  - forced 0 when ZERO_R0=1 and ra[k]=0.
- any_busy = OR of the busy vector (registered state only, no bypass).
- Reset (rst low, asynchronous):
  - every mem entry = 0 and every busy bit = 0 immediately;
  - while rst is low: rd=0 on all ports, rbusy=0, any_busy=0, and writes and issues are ignored.
- Reset asserted mid-operation discards all pending writes and busy bits. After release, the first rising edge with rst high performs normal updates.

## Timing
- Read latency: 0 cycles (combinational from ra, we*, wa*, wd*).
- Write latency: data appears in mem after the rising edge and is visible through bypass in the same cycle.
- Busy set: visible on rbusy the cycle after the iss edge.
- Busy clear: rbusy drops in the same cycle as the write (bypass), and busy is cleared from the next cycle.
- Reset outputs:
  - rd = 0 on all ports;
  - rbusy = 0 on all ports;
  - any_busy = 0.
- No handshake; inputs are sampled every rising edge; no backpressure.
- Width rules:
  - addresses are unsigned and index the full depth;
  - with AW bits, the depth is always exactly 2^AW, so there are no out-of-range addresses.

## Test plan
- **Reset:** load r5=0x1234 and set busy[5], then pulse rst low mid-cycle. Required: rd=0 and rbusy=0 immediately; after release, ra0=5 reads 0.
- **Write/read and r0:**
  - we0, wa0=3, wd0=0xDEADBEEF at edge 1, then ra0=3 reads 0xDEADBEEF.
  - wa0=0, wd0=0xFFFF_FFFF, then ra1=0 reads 0.
- **Dual-write collision and bypass:**
  - Same cycle: we0 wa0=7 wd0=0x11 and we1 wa1=7 wd1=0x22, with ra0=7. Required: rd0=0x22 in that cycle and 0x22 after the edge.
  - Port 0 alone writing 0x33 to r8 with ra1=8: rd1=0x33 in the same cycle.
- **Scoreboard lifecycle:**
  - iss with iss_a=9: the next cycle, ra0=9 gives rbusy0=1 and any_busy=1.
  - we1 wa1=9 wd1=0x55: that cycle rbusy0=0 and rd0=0x55; the next cycle busy[9]=0 and any_busy=0.
- **Set/clear race:**
  - busy[4]=1; same cycle: we0 wa0=4 and iss iss_a=4. Required: busy[4] remains 1 the next cycle, while mem[4] is updated.
  - iss_a=0: rbusy never asserts for ra=0.
- **Parameter sweep:** DW=16, AW=3, NRD=4. Write r1..r7 with distinct values, then read all four ports simultaneously with different addresses; every port returns the correct value. Repeat with ZERO_R0=0: r0 is writable and readable.
